// File: rtl/subtractor.sv
// Lane-parallel subtractor: each LANE_BITS-wide lane computes dd - aa independently.
// The difference, the per-lane borrow and a valid flag are registered with one cycle of latency.
module subtractor #(
    parameter int unsigned NUM_BITS  = 512,
    parameter int unsigned LANE_BITS = 8,
    localparam int unsigned LANES    = NUM_BITS / LANE_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] dd,
    input  logic [NUM_BITS-1:0] aa,
    output logic [NUM_BITS-1:0] difference,
    output logic [LANES-1:0]    borrow,
    output logic                out_valid
);

    logic [NUM_BITS-1:0] w_diff;
    logic [LANES-1:0]    w_borrow;

    logic [NUM_BITS-1:0] r_diff;
    logic [LANES-1:0]    r_borrow;
    logic                r_valid;

    // Zero-extending each lane by one bit makes the extra MSB the lane borrow.
    // Every lane has its own subtractor, so no borrow can reach a neighbouring lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign {w_borrow[g], w_diff[g*LANE_BITS +: LANE_BITS]} =
            {1'b0, dd[g*LANE_BITS +: LANE_BITS]} - {1'b0, aa[g*LANE_BITS +: LANE_BITS]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_diff   <= w_diff;
                r_borrow <= w_borrow;
            end
        end
    end

    assign difference = r_diff;
    assign borrow     = r_borrow;
    assign out_valid  = r_valid;

endmodule

// File: tb/tb_subtractor.sv
// Testbench for subtractor: a table of directed vectors, a walk across every lane,
// and hand-written hold and reset sequences.
module tb_subtractor;

    localparam int unsigned NB = 512;
    localparam int unsigned LN = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [NB-1:0] dd;
    logic [NB-1:0] aa;
    logic [NB-1:0] difference;
    logic [LN-1:0] borrow;
    logic          out_valid;

    int unsigned n_total;
    int unsigned n_pass;

    typedef struct {
        string         name;
        logic [NB-1:0] dd;
        logic [NB-1:0] aa;
        logic [NB-1:0] exp_diff;
        logic [LN-1:0] exp_borrow;
    } vec_t;

    vec_t tv[7];

    subtractor #(.NUM_BITS(512), .LANE_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .dd         (dd),
        .aa         (aa),
        .difference (difference),
        .borrow     (borrow),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive one operand pair before a rising edge and sample #1 after it.
    task automatic step(input logic v, input logic [NB-1:0] d, input logic [NB-1:0] a);
        @(negedge clk);
        in_valid = v;
        dd       = d;
        aa       = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NB-1:0] held_diff;
        logic [LN-1:0] held_borrow;
        logic [NB-1:0] lane_d, lane_a, lane_e;
        logic [LN-1:0] lane_b;

        n_total = 0;
        n_pass  = 0;

        tv[0] = '{"lane0",     512'h43,          512'h02,          512'h41,          64'h0};
        tv[1] = '{"wrap_l38",  '0,               512'h01 << 304,   512'hFF << 304,   64'h1 << 38};
        tv[2] = '{"top_lane",  512'h33 << 504,   512'h05 << 504,   512'h2E << 504,   64'h0};
        tv[3] = '{"wrap_l0",   512'h0100,        512'h01,          512'h01FF,        64'h1};
        tv[4] = '{"mixed",     512'h07_05_80,    512'h05_07_7F,    512'h02_FE_01,    64'h2};
        tv[5] = '{"ones_ones", '1,               '1,               '0,               64'h0};
        tv[6] = '{"zero_ones", '0,               '1,               {64{8'h01}},      '1};

        // Reset held with live operands and in_valid high.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        dd       = '1;
        aa       = 512'h5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff",   difference,             '0);
        chk("rst_borrow", {{(NB-LN){1'b0}}, borrow}, '0);
        chk("rst_valid",  {{(NB-1){1'b0}}, out_valid}, '0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(1'b1, tv[i].dd, tv[i].aa);
            chk({tv[i].name, "_diff"},   difference, tv[i].exp_diff);
            chk({tv[i].name, "_borrow"}, {{(NB-LN){1'b0}}, borrow}, {{(NB-LN){1'b0}}, tv[i].exp_borrow});
            chk({tv[i].name, "_valid"},  {{(NB-1){1'b0}}, out_valid}, 512'h1);
        end

        // in_valid low: outputs hold the all-lanes 0x01 result, out_valid drops.
        step(1'b0, 512'h1234, 512'h4321);
        chk("hold_diff",   difference, {64{8'h01}});
        chk("hold_borrow", {{(NB-LN){1'b0}}, borrow}, {{(NB-LN){1'b0}}, {LN{1'b1}}});
        chk("hold_valid",  {{(NB-1){1'b0}}, out_valid}, '0);
        step(1'b0, '0, '1);
        chk("hold2_diff",  difference, {64{8'h01}});

        // Walk: even lanes 0x80-0x01=0x7F, odd lanes 0x10-0x20=0xF0 with borrow.
        for (int k = 0; k < 64; k++) begin
            lane_d = ((k % 2) == 1) ? 512'h10 : 512'h80;
            lane_a = ((k % 2) == 1) ? 512'h20 : 512'h01;
            lane_e = ((k % 2) == 1) ? 512'hF0 : 512'h7F;
            lane_b = ((k % 2) == 1) ? (64'h1 << k) : 64'h0;
            step(1'b1, lane_d << (8 * k), lane_a << (8 * k));
            chk($sformatf("walk%0d_diff", k),   difference, lane_e << (8 * k));
            chk($sformatf("walk%0d_borrow", k), {{(NB-LN){1'b0}}, borrow}, {{(NB-LN){1'b0}}, lane_b});
        end

        step(1'b1, '0, '0);
        chk("zero_diff",   difference, '0);
        chk("zero_borrow", {{(NB-LN){1'b0}}, borrow}, '0);
        chk("zero_valid",  {{(NB-1){1'b0}}, out_valid}, 512'h1);

        // Asynchronous reset between edges clears a loaded result at once.
        step(1'b1, 512'h43, 512'h44);
        held_diff   = difference;
        held_borrow = borrow;
        chk("pre_rst_diff",   held_diff, 512'hFF);
        chk("pre_rst_borrow", {{(NB-LN){1'b0}}, held_borrow}, 512'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_diff",   difference, '0);
        chk("async_rst_borrow", {{(NB-LN){1'b0}}, borrow}, '0);
        chk("async_rst_valid",  {{(NB-1){1'b0}}, out_valid}, '0);
        @(posedge clk);
        #1;
        chk("rst_held_diff",  difference, '0);
        chk("rst_held_valid", {{(NB-1){1'b0}}, out_valid}, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {{(NB-1){1'b0}}, out_valid}, '0);
        chk("post_rst_diff",  difference, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
